// File: rtl/color_det_pkg.sv
// Shared types and defaults for the RGB565 video stream used by the colour-detection path.
package color_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tx_state_e;

  localparam int DEF_TX_DATA_BITWIDTH = 16;
  localparam int DEF_H_ACTIVE         = 1024;
  localparam int DEF_H_FP             = 24;
  localparam int DEF_H_SYNC           = 136;
  localparam int DEF_H_BP             = 160;
  localparam int DEF_V_ACTIVE         = 768;
  localparam int DEF_V_FP             = 3;
  localparam int DEF_V_SYNC           = 6;
  localparam int DEF_V_BP             = 29;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Same field split the receive side uses on incoming pixels.
  function automatic rgb565_t rgb565_split(input logic [15:0] px);
    return rgb565_t'(px);
  endfunction

endpackage

// File: rtl/rgb565_stream_tx_if.sv
// Producer handshake plus the outgoing RGB565 raster stream of the transmitter.
interface rgb565_stream_tx_if #(
  parameter int TX_DATA_BITWIDTH = 16
);
  logic                        enable_i;
  logic [TX_DATA_BITWIDTH-1:0] pix_data_i;
  logic                        pix_valid_i;
  logic                        pix_ready_o;
  logic [TX_DATA_BITWIDTH-1:0] rgb_o;
  logic                        hsync_o;
  logic                        vsync_o;
  logic                        de_o;
  logic                        frame_done_o;
  logic                        underflow_o;

  modport master (
    input  enable_i, pix_data_i, pix_valid_i,
    output pix_ready_o, rgb_o, hsync_o, vsync_o, de_o, frame_done_o, underflow_o
  );

  modport slave (
    output enable_i, pix_data_i, pix_valid_i,
    input  pix_ready_o, rgb_o, hsync_o, vsync_o, de_o, frame_done_o, underflow_o
  );
endinterface

// File: rtl/video_timing_cnt.sv
// Raster h/v position counters with combinational region decode of the current position.
module video_timing_cnt #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic last
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_MAX = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_MAX = VW'(V_TOTAL - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_end;
  logic          v_end;
  logic [31:0]   hc;
  logic [31:0]   vc;

  assign h_end = (h_cnt == H_MAX);
  assign v_end = (v_cnt == V_MAX);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (run) begin
      if (h_end) begin
        h_cnt <= '0;
        v_cnt <= v_end ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Widen before comparing so region bounds equal to the total never overflow the counter width.
  assign hc = 32'(h_cnt);
  assign vc = 32'(v_cnt);

  assign active = run && (hc < H_ACTIVE) && (vc < V_ACTIVE);
  assign hsync  = run && (hc >= H_ACTIVE + H_FP) && (hc < H_ACTIVE + H_FP + H_SYNC);
  assign vsync  = run && (vc >= V_ACTIVE + V_FP) && (vc < V_ACTIVE + V_FP + V_SYNC);
  assign last   = run && h_end && v_end;

endmodule

// File: rtl/rgb565_stream_tx.sv
// RGB565 raster transmitter: pulls pixels over valid/ready and emits registered rgb/hsync/vsync/de.
module rgb565_stream_tx
  import color_det_pkg::*;
#(
  parameter int TX_DATA_BITWIDTH = DEF_TX_DATA_BITWIDTH,
  parameter int H_ACTIVE         = DEF_H_ACTIVE,
  parameter int H_FP             = DEF_H_FP,
  parameter int H_SYNC           = DEF_H_SYNC,
  parameter int H_BP             = DEF_H_BP,
  parameter int V_ACTIVE         = DEF_V_ACTIVE,
  parameter int V_FP             = DEF_V_FP,
  parameter int V_SYNC           = DEF_V_SYNC,
  parameter int V_BP             = DEF_V_BP
) (
  input logic              sys_clk,
  input logic              sys_rst,
  rgb565_stream_tx_if.master bus
);

  tx_state_e state;
  logic      run;
  logic      clear;
  logic      active;
  logic      hsync;
  logic      vsync;
  logic      last;
  logic      xfer;

  assign run   = (state != IDLE);
  assign clear = (state == IDLE);

  video_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .run    (run),
    .clear  (clear),
    .active (active),
    .hsync  (hsync),
    .vsync  (vsync),
    .last   (last)
  );

  assign bus.pix_ready_o = active;
  assign xfer            = active && bus.pix_valid_i;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state            <= IDLE;
      bus.rgb_o        <= '0;
      bus.hsync_o      <= 1'b0;
      bus.vsync_o      <= 1'b0;
      bus.de_o         <= 1'b0;
      bus.frame_done_o <= 1'b0;
      bus.underflow_o  <= 1'b0;
    end else begin
      bus.de_o         <= active;
      bus.rgb_o        <= xfer ? bus.pix_data_i : '0;
      bus.hsync_o      <= hsync;
      bus.vsync_o      <= vsync;
      bus.frame_done_o <= last;
      // A starved active slot still shows de with a black pixel; the flag records it.
      if (active && !bus.pix_valid_i) bus.underflow_o <= 1'b1;
      unique case (state)
        IDLE: begin
          if (bus.enable_i) begin
            state           <= RUN;
            bus.underflow_o <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.enable_i) state <= last ? IDLE : DRAIN;
        end
        DRAIN: begin
          if (bus.enable_i) state <= RUN;
          else if (last)    state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb565_stream_tx.sv
// Scoreboard bench for rgb565_stream_tx on a small 8x6 raster (48-cycle frame).
module tb_rgb565_stream_tx;
  import color_det_pkg::*;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        de;
    logic [15:0] rgb;
    logic        hs;
    logic        vs;
    logic        fd;
    logic        uf;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst;

  rgb565_stream_tx_if #(.TX_DATA_BITWIDTH(16)) bus();

  rgb565_stream_tx #(
    .TX_DATA_BITWIDTH (16),
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  exp_t        q[$];
  logic [15:0] seen[$];
  int          checks = 0;
  int          errors = 0;
  int          n_fd = 0, n_hs = 0, n_vs = 0;

  // reference model: FSM state, frame position (0..47) and sticky flag
  tx_state_e ms = IDLE;
  int        mpos = 0;
  logic      muf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock: predict this cycle, check ready, advance across the edge, check registered outputs.
  task automatic cyc();
    exp_t      e;
    exp_t      g;
    int        h, v;
    logic      run, act, lst, xfer, nuf;
    tx_state_e ns;
    h    = mpos % HT;
    v    = mpos / HT;
    run  = (ms != IDLE);
    act  = run && h < HA && v < VA;
    lst  = run && mpos == FRAME - 1;
    xfer = act && bus.pix_valid_i && !sys_rst;
    chk("ready", bus.pix_ready_o, act);

    nuf = muf | (act && !bus.pix_valid_i);
    ns  = ms;
    case (ms)
      IDLE:    if (bus.enable_i) begin ns = RUN; nuf = 1'b0; end
      RUN:     if (!bus.enable_i) ns = lst ? IDLE : DRAIN;
      default: if (bus.enable_i) ns = RUN; else if (lst) ns = IDLE;
    endcase

    e.de  = act;
    e.rgb = (act && bus.pix_valid_i) ? bus.pix_data_i : 16'h0000;
    e.hs  = run && h >= HA + HF && h < HA + HF + HS;
    e.vs  = run && v >= VA + VF && v < VA + VF + VS;
    e.fd  = lst;
    e.uf  = nuf;
    if (sys_rst) begin
      e    = '0;
      ms   = IDLE;
      mpos = 0;
      muf  = 1'b0;
    end else begin
      mpos = (ms == IDLE) ? 0 : (mpos + 1) % FRAME;
      ms   = ns;
      muf  = nuf;
    end
    q.push_back(e);

    @(posedge sys_clk);
    #1;
    g = q.pop_front();
    chk("de", bus.de_o, g.de);
    chk("rgb", bus.rgb_o, g.rgb);
    chk("hsync", bus.hsync_o, g.hs);
    chk("vsync", bus.vsync_o, g.vs);
    chk("frame_done", bus.frame_done_o, g.fd);
    chk("underflow", bus.underflow_o, g.uf);
    if (bus.de_o === 1'b1) seen.push_back(bus.rgb_o);
    if (bus.frame_done_o === 1'b1) n_fd++;
    if (bus.hsync_o === 1'b1) n_hs++;
    if (bus.vsync_o === 1'b1) n_vs++;
    if (xfer) bus.pix_data_i = bus.pix_data_i + 16'd1;
  endtask

  initial begin
    int          k;
    int          fd0;
    logic [15:0] held;
    sys_rst         = 1'b1;
    bus.enable_i    = 1'b0;
    bus.pix_valid_i = 1'b0;
    bus.pix_data_i  = 16'h0000;
    @(posedge sys_clk);
    #1;

    // 1: reset then idle with enable low
    cyc();
    sys_rst = 1'b0;
    repeat (20) cyc();
    chk("t1_no_de", 32'(seen.size()), 0);

    // 2: continuous producer, two frames
    seen.delete();
    n_fd = 0; n_hs = 0; n_vs = 0;
    bus.enable_i    = 1'b1;
    bus.pix_valid_i = 1'b1;
    bus.pix_data_i  = 16'h0001;
    cyc();
    repeat (FRAME) cyc();
    chk("t2_px_count", 32'(seen.size()), 12);
    for (int i = 0; i < 12 && i < seen.size(); i++) chk("t2_px_order", seen[i], 32'(i + 1));
    chk("t2_hs_cycles", n_hs, 12);
    chk("t2_vs_cycles", n_vs, 8);
    chk("t2_fd_one", n_fd, 1);
    repeat (FRAME) cyc();
    chk("t2_fd_two", n_fd, 2);

    // 3: producer misses the 3rd pixel of line 1
    seen.delete();
    repeat (FRAME) begin
      bus.pix_valid_i = (mpos != HT + 2);
      cyc();
    end
    bus.pix_valid_i = 1'b1;
    chk("t3_px_count", 32'(seen.size()), 12);
    if (seen.size() == 12) begin
      chk("t3_before_gap", seen[5], 16'd30);
      chk("t3_gap_black", seen[6], 16'd0);
      chk("t3_no_slip", seen[7], 16'd31);
      chk("t3_last_px", seen[11], 16'd35);
    end
    chk("t3_uf_set", bus.underflow_o, 1);

    // 4: enable drops on the 10th cycle; frame must still complete
    fd0 = n_fd;
    repeat (9) cyc();
    bus.enable_i = 1'b0;
    k = 0;
    while (ms != IDLE && k < 100) begin
      cyc();
      k++;
    end
    chk("t4_drain_len", k, 39);
    chk("t4_fd_pulse", n_fd, fd0 + 1);
    repeat (5) cyc();
    chk("t4_idle_de", bus.de_o, 0);
    chk("t4_idle_ready", bus.pix_ready_o, 0);
    chk("t3_uf_sticky", bus.underflow_o, 1);
    bus.enable_i = 1'b1;
    cyc();
    chk("t3_uf_clr", bus.underflow_o, 0);

    // 5: reset at the 2nd active pixel of line 2, then resume
    repeat (2 * HT + 1) cyc();
    held    = bus.pix_data_i;
    sys_rst = 1'b1;
    cyc();
    sys_rst = 1'b0;
    chk("t5_rst_de", bus.de_o, 0);
    chk("t5_rst_rgb", bus.rgb_o, 0);
    seen.delete();
    k = 0;
    while (seen.size() == 0 && k < 200) begin
      cyc();
      k++;
    end
    chk("t5_first_lat", k, 2);
    if (seen.size() > 0) chk("t5_first_px", seen[0], held);
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
